// File: rtl/isa_bus_pkg.sv
// Shared types and default timing for the ISA I/O cycle engine.
// The cycle counts assume a 50 MHz clock.
package isa_bus_pkg;

    typedef enum logic [2:0] {
        ST_RST_DRV,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } isa_state_t;

    localparam int unsigned SETUP_CYC_DEF  = 2;
    localparam int unsigned STROBE_CYC_DEF = 25;
    localparam int unsigned HOLD_CYC_DEF   = 3;
    localparam int unsigned RESET_CYC_DEF  = 100;

    // Encoding matches avs_byteenable so a request's lane list is a direct cast.
    typedef enum logic [1:0] {
        LANES_NONE = 2'b00,
        LANES_0    = 2'b01,
        LANES_1    = 2'b10,
        LANES_BOTH = 2'b11
    } lane_list_t;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/isa_cycle_timer.sv
// Loadable down-counter; o_term is high while the count sits at zero.
// Loading D-1 on entry to a state therefore keeps that state for D cycles.
module isa_cycle_timer #(
    parameter int unsigned           WIDTH   = 7,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_term
);

    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_term = (r_count == '0);

endmodule

// File: rtl/isa_io_cycle_engine.sv
// Avalon-MM slave to 8-bit ISA I/O cycle converter with power-up RESET DRV.
// Every ISA output and waitrequest is a register fed from next-state values.
module isa_io_cycle_engine
    import isa_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = SETUP_CYC_DEF,
    parameter int unsigned STROBE_CYC = STROBE_CYC_DEF,
    parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
    parameter int unsigned RESET_CYC  = RESET_CYC_DEF
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [14:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [1:0]  avs_byteenable,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [15:0] isa_address,
    output logic        isa_aen,
    output logic [7:0]  isa_data_o,
    output logic        isa_data_oe,
    input  logic [7:0]  isa_data_i,
    output logic        isa_ior,
    output logic        isa_iow,
    output logic        isa_reset
);

    localparam int unsigned   TW        = $clog2(max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RESET_CYC) + 1);
    localparam logic [TW-1:0] LD_SETUP  = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] LD_STROBE = TW'(STROBE_CYC - 1);
    localparam logic [TW-1:0] LD_HOLD   = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] LD_RESET  = TW'(RESET_CYC - 1);

    isa_state_t    r_state, w_state_next;
    logic [14:0]   r_addr, w_addr_next;
    logic [15:0]   r_wdata, w_wdata_next;
    logic [15:0]   r_rdata, w_rdata_next;
    logic          r_write, w_write_next;
    lane_list_t    r_lanes, w_lanes_next;
    logic          r_lane, w_lane_next;
    logic [7:0]    r_data_o, w_data_o_next;
    logic          r_waitreq, r_aen, r_oe, r_ior, r_iow, r_reset;
    logic          w_active, w_load, w_term;
    logic [TW-1:0] w_load_val;

    isa_cycle_timer #(
        .WIDTH   (TW),
        .RST_VAL (LD_RESET)
    ) u_timer (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_term  (w_term)
    );

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_rdata_next = r_rdata;
        w_write_next = r_write;
        w_lanes_next = r_lanes;
        w_lane_next  = r_lane;

        case (r_state)
            ST_RST_DRV: if (w_term) w_state_next = ST_IDLE;
            ST_IDLE: begin
                if (avs_read || avs_write) begin
                    w_addr_next  = avs_address;
                    w_wdata_next = avs_writedata;
                    w_write_next = avs_write;
                    w_lanes_next = lane_list_t'(avs_byteenable);
                    w_lane_next  = !avs_byteenable[0];
                    w_rdata_next = '0;
                    w_state_next = (w_lanes_next == LANES_NONE) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP:  if (w_term) w_state_next = ST_STROBE;
            ST_STROBE: begin
                if (w_term) begin
                    w_state_next = ST_HOLD;
                    // Data is captured on the same edge that releases IOR#.
                    if (!r_write) begin
                        if (r_lane) w_rdata_next[15:8] = isa_data_i;
                        else        w_rdata_next[7:0]  = isa_data_i;
                    end
                end
            end
            ST_HOLD: begin
                if (w_term) begin
                    if (!r_lane && (r_lanes == LANES_BOTH)) begin
                        w_lane_next  = 1'b1;
                        w_state_next = ST_SETUP;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_RST_DRV;
        endcase

        w_active = (w_state_next == ST_SETUP) || (w_state_next == ST_STROBE) ||
                   (w_state_next == ST_HOLD);

        w_data_o_next = r_data_o;
        if (w_active && w_write_next)
            w_data_o_next = w_lane_next ? w_wdata_next[15:8] : w_wdata_next[7:0];

        w_load     = w_active && (w_state_next != r_state);
        w_load_val = '0;
        if (w_state_next == ST_SETUP)       w_load_val = LD_SETUP;
        else if (w_state_next == ST_STROBE) w_load_val = LD_STROBE;
        else if (w_state_next == ST_HOLD)   w_load_val = LD_HOLD;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= ST_RST_DRV;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_write   <= 1'b0;
            r_lanes   <= LANES_NONE;
            r_lane    <= 1'b0;
            r_data_o  <= '0;
            r_waitreq <= 1'b1;
            r_aen     <= 1'b1;
            r_oe      <= 1'b0;
            r_ior     <= 1'b1;
            r_iow     <= 1'b1;
            r_reset   <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_wdata   <= w_wdata_next;
            r_rdata   <= w_rdata_next;
            r_write   <= w_write_next;
            r_lanes   <= w_lanes_next;
            r_lane    <= w_lane_next;
            r_data_o  <= w_data_o_next;
            r_waitreq <= (w_state_next != ST_DONE);
            r_aen     <= !w_active;
            r_oe      <= w_active && w_write_next;
            r_ior     <= !((w_state_next == ST_STROBE) && !w_write_next);
            r_iow     <= !((w_state_next == ST_STROBE) && w_write_next);
            r_reset   <= (w_state_next == ST_RST_DRV);
        end
    end

    assign avs_readdata    = r_rdata;
    assign avs_waitrequest = r_waitreq;
    assign isa_address     = {r_addr, r_lane};
    assign isa_aen         = r_aen;
    assign isa_data_o      = r_data_o;
    assign isa_data_oe     = r_oe;
    assign isa_ior         = r_ior;
    assign isa_iow         = r_iow;
    assign isa_reset       = r_reset;

endmodule
